// File: rtl/pong_pkg.sv
// pong_pkg: shared move-code constants and paddle FSM state type
package pong_pkg;
  localparam logic [2:0] MOVE_LEFT   = 3'b100;
  localparam logic [2:0] MOVE_CENTER = 3'b010;
  localparam logic [2:0] MOVE_RIGHT  = 3'b001;
  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer followed by a stable-level debouncer
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);
  localparam int W = $clog2(DEB_CYCLES) + 1;
  logic s1, s2;
  logic [W-1:0] cnt;
  // synchronize, then accept a new level only after DEB_CYCLES differing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (cnt == W'(DEB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/paddle_move_encoder.sv
// paddle_move_encoder: debounced buttons to left/centre/right pulse codes with auto-repeat
module paddle_move_encoder
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [2:0] move_code,
  output logic       active
);
  localparam int CW = $clog2(max3(PULSE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1;
  logic sl, sr, sl_q, sr_q, rl, rr, dir_btn, opp_btn;
  logic dir, dir_n, first, first_n;
  logic [CW-1:0] pcnt, pcnt_n, rcnt, rcnt_n;
  state_t state, state_n;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_left  (.clk(clk), .rst(rst), .btn(btn_left),  .level(sl));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_right (.clk(clk), .rst(rst), .btn(btn_right), .level(sr));
  assign rl = sl & ~sl_q;
  assign rr = sr & ~sr_q;
  assign dir_btn = dir ? sr : sl;
  assign opp_btn = dir ? sl : sr;
  // next state: single-button presses start a pulse, holding the button repeats it
  always_comb begin
    state_n = state;
    dir_n   = dir;
    first_n = first;
    pcnt_n  = pcnt;
    rcnt_n  = rcnt;
    case (state)
      IDLE: begin
        if (rl && !rr && !sr) begin
          state_n = PULSE;
          dir_n   = 1'b0;
          first_n = 1'b1;
          pcnt_n  = '0;
        end else if (rr && !rl && !sl) begin
          state_n = PULSE;
          dir_n   = 1'b1;
          first_n = 1'b1;
          pcnt_n  = '0;
        end
      end
      PULSE: begin
        if (pcnt == CW'(PULSE_CYCLES - 1)) begin
          state_n = HOLD;
          pcnt_n  = '0;
          rcnt_n  = first ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE);
        end else pcnt_n = pcnt + 1'b1;
      end
      HOLD: begin
        if (!dir_btn) state_n = IDLE;
        else if (!opp_btn) begin
          if (rcnt == '0) begin
            state_n = PULSE;
            first_n = 1'b0;
            pcnt_n  = '0;
          end else rcnt_n = rcnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters, edge history and outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b0;
      first     <= 1'b0;
      pcnt      <= '0;
      rcnt      <= '0;
      sl_q      <= 1'b0;
      sr_q      <= 1'b0;
      move_code <= MOVE_CENTER;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      first     <= first_n;
      pcnt      <= pcnt_n;
      rcnt      <= rcnt_n;
      sl_q      <= sl;
      sr_q      <= sr;
      move_code <= (state_n == PULSE) ? (dir_n ? MOVE_RIGHT : MOVE_LEFT) : MOVE_CENTER;
      active    <= (state_n == PULSE);
    end
  end
endmodule

// File: tb/tb_paddle_move_encoder.sv
// tb_paddle_move_encoder: vector table, corner sequences and random run against a reference model
module tb_paddle_move_encoder;
  localparam int DEB = 4, PUL = 2, RDL = 8, RRT = 4;
  logic clk = 1'b0, rst = 1'b1, btn_left = 1'b0, btn_right = 1'b0;
  logic [2:0] move_code;
  logic active;
  int errors = 0, checks = 0, cyc = 0;
  logic [2:0] prev_code = 3'b010;
  int starts[$];
  typedef struct {bit l; bit r; logic [2:0] code; bit act;} vec_t;
  vec_t tv[24];
  int exp_rep[6] = '{7, 18, 25, 32, 39, 46};
  int exp_frz[4] = '{7, 38, 45, 52};
  bit h1[2], h2[2], st[2], st_old[2];
  int run[2];
  int pulse_rem, wait_c;
  bit holding, mdir, mfirst;

  paddle_move_encoder #(.DEB_CYCLES(DEB), .PULSE_CYCLES(PUL), .REPEAT_DELAY(RDL), .REPEAT_RATE(RRT)) dut (
    .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
    .move_code(move_code), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      h1[b] = 0; h2[b] = 0; st[b] = 0; st_old[b] = 0; run[b] = 0;
    end
    pulse_rem = 0; wait_c = 0; holding = 0; mdir = 0; mfirst = 0;
  endtask

  task automatic model_step(input bit l, input bit r);
    bit rise[2];
    bit raw[2];
    int own, opp;
    raw[0] = l; raw[1] = r;
    for (int b = 0; b < 2; b++) rise[b] = st[b] && !st_old[b];
    own = mdir ? 1 : 0;
    opp = mdir ? 0 : 1;
    if (pulse_rem > 0) begin
      pulse_rem--;
      if (pulse_rem == 0) begin
        holding = 1;
        wait_c = mfirst ? RDL : RRT;
      end
    end else if (holding) begin
      if (!st[own]) holding = 0;
      else if (!st[opp]) begin
        if (wait_c == 0) begin
          holding = 0; pulse_rem = PUL; mfirst = 0;
        end else wait_c--;
      end
    end else if (rise[0] && !rise[1] && !st[1]) begin
      pulse_rem = PUL; mdir = 0; mfirst = 1;
    end else if (rise[1] && !rise[0] && !st[0]) begin
      pulse_rem = PUL; mdir = 1; mfirst = 1;
    end
    for (int b = 0; b < 2; b++) begin
      st_old[b] = st[b];
      if (h2[b] == st[b]) run[b] = 0;
      else begin
        run[b]++;
        if (run[b] == DEB) begin
          st[b] = h2[b];
          run[b] = 0;
        end
      end
      h2[b] = h1[b];
      h1[b] = raw[b];
    end
  endtask

  function automatic logic [2:0] m_code();
    return (pulse_rem > 0) ? (mdir ? 3'b001 : 3'b100) : 3'b010;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(btn_left, btn_right);
    @(negedge clk);
    cyc++;
    chk("model_code", int'(move_code), int'(m_code()));
    chk("model_active", int'(active), (pulse_rem > 0) ? 1 : 0);
    if (move_code != 3'b010 && prev_code == 3'b010) starts.push_back(cyc);
    prev_code = move_code;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_left = 1'b0; btn_right = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    prev_code = 3'b010;
    starts.delete();
  endtask

  task automatic chk_starts(input string name, input int idx, input int exp);
    chk(name, (starts.size() > idx) ? starts[idx] : -1, exp);
  endtask

  initial begin
    for (int i = 0; i < 24; i++)
      tv[i] = '{(i < 6), 1'b0, (i == 6 || i == 7) ? 3'b100 : 3'b010, (i == 6 || i == 7)};
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_code", int'(move_code), 3'b010);
    chk("reset_active", int'(active), 0);
    do_reset();
    for (int i = 0; i < 24; i++) begin
      btn_left = tv[i].l;
      btn_right = tv[i].r;
      tick();
      chk("vec_code", int'(move_code), int'(tv[i].code));
      chk("vec_active", int'(active), int'(tv[i].act));
    end
    chk("single_pulses", starts.size(), 1);
    chk_starts("single_start", 0, 7);
    do_reset();
    btn_right = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    btn_right = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("repeat_pulses", starts.size(), 6);
    for (int k = 0; k < 6; k++) chk_starts("repeat_start", k, exp_rep[k]);
    chk("repeat_idle_code", int'(move_code), 3'b010);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      btn_right = ((i / 2) % 2) == 0;
      tick();
    end
    btn_right = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("bounce_pulses", starts.size(), 0);
    do_reset();
    btn_left = 1'b1;
    btn_right = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("both_same_cycle", starts.size(), 0);
    btn_left = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    btn_left = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("left_while_right_held", starts.size(), 0);
    btn_left = 1'b0;
    btn_right = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    do_reset();
    btn_left = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    btn_right = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    btn_right = 1'b0;
    for (int i = 0; i < 21; i++) tick();
    btn_left = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("freeze_pulses", starts.size(), 4);
    for (int k = 0; k < 4; k++) chk_starts("freeze_start", k, exp_frz[k]);
    do_reset();
    btn_left = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_code", int'(move_code), 3'b100);
    rst = 1'b1;
    #1;
    chk("rst_async_code", int'(move_code), 3'b010);
    chk("rst_async_active", int'(active), 0);
    btn_left = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    starts.delete();
    prev_code = 3'b010;
    for (int i = 0; i < 50; i++) tick();
    chk("post_rst_quiet", starts.size(), 0);
    btn_left = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    starts.delete();
    prev_code = 3'b010;
    for (int i = 0; i < 12; i++) tick();
    chk("held_thru_rst_pulses", starts.size(), 1);
    chk_starts("held_thru_rst_start", 0, 7);
    btn_left = 1'b0;
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      int rate;
      rate = (seg % 3 == 0) ? 3 : ((seg % 3 == 1) ? 16 : 40);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, rate - 1) == 0) btn_left = ~btn_left;
        if ($urandom_range(0, rate - 1) == 0) btn_right = ~btn_right;
        rst = ($urandom_range(0, 999) == 0);
        tick();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/paddle_move_encoder.md
# paddle_move_encoder

Turns the two raw paddle push-buttons into the 3-bit movement code consumed by the player-position tracker. A press emits a left or right code, then returns to centre. Holding a button auto-repeats the press. The tracker counts one step per centre-after-side transition, so this block guarantees exactly one such transition per press or repeat. It sits between the board button pins and the player-position tracker, one instance per player.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive synchronized-stable cycles required to accept a button level change (≥1; 250000 on hardware).
- PULSE_CYCLES, 2: cycles a side code is held before returning to centre (≥1).
- REPEAT_DELAY, 8: cycles in centre after the first pulse before the first auto-repeat (≥1).
- REPEAT_RATE, 4: cycles in centre between subsequent auto-repeats (≥1).

Ports:
- clk, input, 1: the single clock; all state is on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- btn_left, input, 1: raw left button, asynchronous to clk, active-high.
- btn_right, input, 1: raw right button, asynchronous to clk, active-high.
- move_code, output, 3: 3'b100 = left, 3'b010 = centre, 3'b001 = right. Never any other value. Registered.
- active, output, 1: high while move_code is a side code (PULSE state). Registered.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer counter clears whenever the synchronized level equals the stable level.
  - Otherwise it counts up. When it reaches DEB_CYCLES, the stable level takes the synchronized level and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the stable level.
- The FSM sees stable levels sl and sr, plus the rising edges of sl and sr (one-cycle, registered from the previous stable value).
- The FSM holds a direction register dir (L/R), a pulse counter and a repeat counter.
- IDLE, move_code = 010:
  - On a rising edge of exactly one of sl/sr while the other is low: latch dir, go to PULSE.
  - Both edges in the same cycle, or an edge while the other stable level is high: stay in IDLE.
- PULSE, move_code = 100 (dir L) or 001 (dir R), active = 1:
  - Stays for PULSE_CYCLES cycles, then goes to HOLD.
  - Button release during PULSE does not shorten it.
- HOLD, move_code = 010:
  - On entry from the first pulse, the repeat counter loads REPEAT_DELAY. On entry from a repeat pulse, it loads REPEAT_RATE.
  - If the dir button's stable level is low: go to IDLE.
  - Else if the opposite stable level is high: the repeat counter freezes and no repeat is emitted.
  - Else the counter decrements. On the cycle it reaches 0, go to PULSE with the same dir.
- A PULSE is always followed by at least one centre cycle, so the tracker steps exactly once per pulse.
- Reset mid-operation: move_code returns to 010 immediately (asynchronously) and state goes to IDLE. Synchronizers, stable levels, edge registers and counters clear to 0.
- A button held through reset release debounces high after reset and produces one pulse.

## Timing
- Reset values: move_code = 3'b010, active = 0, state IDLE, all counters and stable levels 0.
- Press latency: with a raw level change settled before clock edge 0 and held, move_code shows the side code after edge DEB_CYCLES+3.
  - Edges 1–2: synchronizer.
  - Edge DEB_CYCLES+2: stable level updates.
  - Edge DEB_CYCLES+3: FSM registers PULSE.
- Side code duration is exactly PULSE_CYCLES cycles.
- First repeat starts REPEAT_DELAY+1 cycles after HOLD entry. Later repeats start REPEAT_RATE+1 cycles after HOLD entry.
  - Steady-state repeat period is PULSE_CYCLES+REPEAT_RATE+1.
- Release latency: IDLE is reached DEB_CYCLES+3 edges after a settled release, unless a PULSE is still in progress, in which case the PULSE completes first.

## Structure
- Shared package pong_pkg holds:
  - the move-code constants MOVE_LEFT = 3'b100, MOVE_CENTER = 3'b010, MOVE_RIGHT = 3'b001;
  - the FSM state enum (IDLE, PULSE, HOLD).
- The player-position tracker imports the same move-code constants.
- Sub-module btn_debounce (synchronizer + debouncer, parameter DEB_CYCLES) is instantiated twice.
- FSM and counters live in the top module. Counter widths are $clog2 of the max parameter + 1.

## Test plan
All scenarios use default parameters.
- Reset: assert rst mid-PULSE → move_code = 010 and active = 0 in the same cycle. After release with buttons low, move_code stays 010 for 50 cycles.
- Single press: btn_left high 6 cycles, then low → move_code = 100 for exactly 2 cycles starting at edge 7, then 010 and stays 010. Exactly one 100→010 transition occurs.
- Bounce rejection: btn_right toggles every 2 cycles for 20 cycles, then stays low → move_code never leaves 010.
- Auto-repeat: btn_right held 40 cycles → first 001 at edge 7, second 001 at edge 7+2+9 = 18, then every 2+5 = 7 cycles. Release → no further pulses once IDLE is reached.
- Simultaneous buttons: both raise in the same cycle → no pulse. Left held, then right pressed during HOLD → repeats stop. Right released → left repeats resume with the frozen count.
- Opposite press in IDLE while other held: right held through IDLE (stable high), left pressed → no left pulse.
